// File: rtl/keypad_pkg.sv
// Shared types and the key layout for the 4x4 keypad scanner.
package keypad_pkg;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_res_t;

  localparam key_res_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

  // Indexed by {row, col}; entry 0 is the top-left key.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the active-low keypad row lines.
module row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with frame-level debounce and
// single-cycle key_valid strobes for each accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int CYC_W = $clog2(SCAN_CYCLES);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0] rows_sync;

  row_sync u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rows),
    .q_o (rows_sync)
  );

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             frame_done_q, frame_done_d;
  key_res_t         frame_res_q, frame_res_d;
  logic             frame_multi_q, frame_multi_d;
  key_res_t         prev_res_q, prev_res_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_q, multi_d;

  logic [2:0] col_hits;
  logic [3:0] col_code;
  logic [2:0] sum_hits;
  logic [1:0] sat_hits;
  logic [3:0] merged_code;
  logic [CNT_W-1:0] cnt_next;

  // Keys seen in the column currently being sampled.
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (!rows_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = KEY_MAP[{2'(r), col_q}];
      end
    end
  end

  // The accumulator only needs to tell 0, 1 and "more than one" apart.
  assign sum_hits    = {1'b0, acc_cnt_q} + col_hits;
  assign sat_hits    = (sum_hits > 3'd2) ? 2'd2 : sum_hits[1:0];
  assign merged_code = (col_hits != 3'd0) ? col_code : acc_code_q;

  always_comb begin
    cyc_d         = cyc_q;
    col_d         = col_q;
    acc_cnt_d     = acc_cnt_q;
    acc_code_d    = acc_code_q;
    frame_done_d  = 1'b0;
    frame_res_d   = frame_res_q;
    frame_multi_d = frame_multi_q;
    prev_res_d    = prev_res_q;
    stable_cnt_d  = stable_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    multi_d       = multi_q;
    cnt_next      = stable_cnt_q;

    if (cyc_q == CYC_LAST) begin
      cyc_d = '0;
      col_d = col_q + 2'd1;
      if (col_q == 2'd3) begin
        frame_done_d  = 1'b1;
        frame_res_d   = (sat_hits == 2'd1) ? key_res_t'{valid: 1'b1, code: merged_code} : KEY_NONE;
        frame_multi_d = (sat_hits == 2'd2);
        acc_cnt_d     = '0;
        acc_code_d    = '0;
      end else begin
        acc_cnt_d  = sat_hits;
        acc_code_d = merged_code;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    if (frame_done_q) begin
      multi_d    = frame_multi_q;
      prev_res_d = frame_res_q;
      if (frame_res_q == prev_res_q) begin
        cnt_next = (stable_cnt_q == CNT_MAX) ? CNT_MAX : stable_cnt_q + 1'b1;
      end else begin
        cnt_next = CNT_W'(1);
      end
      stable_cnt_d = cnt_next;
      if (cnt_next == CNT_MAX) begin
        if (frame_res_q.valid) begin
          if (!key_held_q || (frame_res_q.code != key_code_q)) begin
            key_code_d  = frame_res_q.code;
            key_held_d  = 1'b1;
            key_valid_d = 1'b1;
          end
        end else begin
          key_held_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q         <= '0;
      col_q         <= '0;
      acc_cnt_q     <= '0;
      acc_code_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_res_q   <= KEY_NONE;
      frame_multi_q <= 1'b0;
      prev_res_q    <= KEY_NONE;
      stable_cnt_q  <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      col_q         <= col_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      frame_done_q  <= frame_done_d;
      frame_res_q   <= frame_res_d;
      frame_multi_q <= frame_multi_d;
      prev_res_q    <= prev_res_d;
      stable_cnt_q  <= stable_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      multi_q       <= multi_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized frame-level bench for keypad_scanner against a debounce model.
module tb_keypad_scanner;

  localparam int SC    = 8;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SC;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] press_mask = '0;

  int errors = 0;
  int checks = 0;
  int frame_no = 0;

  // Reference model state, updated once per full frame.
  int m_prev, m_cnt, m_held, m_code, m_valid, m_multi;
  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  always #5 clk = ~clk;

  // Physical keypad: a row reads low if a pressed key sits on a driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      rows[r] = ~|(press_mask[r*4 +: 4] & ~cols);
  end

  keypad_scanner #(
    .SCAN_CYCLES     (SC),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  function automatic void model_reset();
    m_prev = -1; m_cnt = 0; m_held = 0; m_code = 0; m_valid = 0; m_multi = 0;
  endfunction

  function automatic void model_eval(input logic [15:0] mask);
    int n, res;
    n   = $countones(mask);
    res = -1;
    if (n == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) res = km[i];
    m_multi = (n > 1);
    if (res == m_prev) m_cnt = (m_cnt + 1 > DF) ? DF : m_cnt + 1;
    else m_cnt = 1;
    m_prev  = res;
    m_valid = 0;
    if (m_cnt == DF) begin
      if (res >= 0) begin
        if (!m_held || res != m_code) begin
          m_code = res; m_held = 1; m_valid = 1;
        end
      end else begin
        m_held = 0;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst cols", cols, 4'b1110);
    check("rst key_code", key_code, 0);
    check("rst key_valid", key_valid, 0);
    check("rst key_held", key_held, 0);
    check("rst multi_key", multi_key, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One full frame with a steady key pattern; the first cycle shows the
  // outcome of the previous frame's evaluation.
  task automatic run_frame(input logic [15:0] mask, input string name);
    int stray, col_bad;
    logic [3:0] exp_cols;
    logic [3:0] one;
    stray   = 0;
    col_bad = 0;
    one     = 4'b0001;
    press_mask = mask;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        check({name, " key_valid"}, key_valid, m_valid);
        check({name, " key_code"}, key_code, m_code);
        check({name, " key_held"}, key_held, m_held);
        check({name, " multi_key"}, multi_key, m_multi);
      end else if (key_valid) begin
        stray++;
      end
      exp_cols = ~(one << ((i / SC) % 4));
      if (cols !== exp_cols) col_bad++;
    end
    check({name, " extra pulses"}, stray, 0);
    check({name, " cols walk"}, col_bad, 0);
    $display("frame %0d %s mask=%04h code=%h held=%0d multi=%0d", frame_no, name, mask,
             key_code, key_held, multi_key);
    frame_no++;
    model_eval(mask);
  endtask

  initial begin
    logic [15:0] m, prev_m;
    int a, b, sel;
    rst = 1'b1;
    model_reset();
    do_reset();

    for (int k = 0; k < 3; k++) run_frame('0, "idle");
    for (int k = 0; k < 6; k++) run_frame(kb(1, 1), "hold5");
    for (int k = 0; k < 4; k++) run_frame('0, "rel5");
    for (int k = 0; k < 5; k++) run_frame(kb(3, 3), "holdD");
    for (int k = 0; k < 10; k++) run_frame((k % 2 == 0) ? kb(2, 1) : 16'h0, "chat8");
    for (int k = 0; k < 5; k++) run_frame(kb(0, 0) | kb(0, 3), "multi");

    for (int k = 0; k < 2; k++) run_frame(kb(0, 2), "pre3");
    repeat (10) @(posedge clk);
    #3;
    do_reset();
    for (int k = 0; k < 5; k++) run_frame(kb(0, 2), "post3");

    prev_m = kb(0, 2);
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        m = prev_m;
      end else if (sel < 8) begin
        m = kb($urandom_range(0, 3), $urandom_range(0, 3));
      end else if (sel == 8) begin
        m = '0;
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        m = kb(a / 4, a % 4) | kb(b / 4, b % 4);
      end
      run_frame(m, "rand");
      prev_m = m;
    end
    run_frame('0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 Pmod keypad (rows in, columns out) and debounces what it reads.
- Emits a single-cycle key_valid strobe with a 4-bit hex key code for each accepted press.
- Sits directly upstream of the game block and drives its dec/button_pressed inputs.
- Runs entirely on the 100 MHz system clock; no derived clocks.

Parameters:
SCAN_CYCLES, 100000, clk cycles each column is driven (1 ms at 100 MHz); must be >= 4
DEBOUNCE_FRAMES, 5, consecutive identical full-scan frames needed to accept a press or release; must be >= 1

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
rows  in  4  keypad row lines, active-low (0 = key in the driven column pressed); rows[0] = top row
cols  out  4  keypad column drives, active-low one-hot; cols[0] = leftmost column
key_code  out  4  hex code of the last accepted key
key_valid  out  1  one-cycle pulse when a new key is accepted
key_held  out  1  high while the accepted key remains debounced-pressed
multi_key  out  1  high while the last completed frame saw more than one key

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: cols=4'b1110, key_code=0, key_valid=0, key_held=0, multi_key=0. All counters and frame accumulators are 0, and the stable candidate is NONE.
- Reset mid-scan or mid-debounce aborts the operation immediately. No partial frame survives.
- Input sync: rows pass through a 2-FF synchronizer; there is no other input filtering.
- Scan: a column counter (0..3) and a cycle counter (0..SCAN_CYCLES-1).
  - cols = ~(1 << col_idx).
  - The synchronized rows are sampled when cycle counter == SCAN_CYCLES-1. Settling plus sync latency fits because SCAN_CYCLES >= 4.
  - Then the cycle counter goes to 0 and col_idx increments, wrapping 3->0.
- Frame: 4 column windows = 4*SCAN_CYCLES cycles. Each sample where a row bit reads 0 counts as a pressed key at (row r, col c).
- Key map, row-major, top to bottom:
  - row 0: 1,2,3,A
  - row 1: 4,5,6,B
  - row 2: 7,8,9,C
  - row 3: 0,F,E,D
- Frame result, evaluated in the cycle after the column-3 sample:
  - 0 keys gives NONE.
  - Exactly 1 key gives that code.
  - More than 1 key gives NONE, and multi_key=1 for the following frame period.
  - multi_key is otherwise 0.
- Debounce counter:
  - If the frame result equals the previous frame result, stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise stable_cnt=1.
- Accept press: when stable_cnt reaches DEBOUNCE_FRAMES on a key result K, and (key_held=0 or K != key_code):
  - key_code<=K, key_held<=1, and key_valid=1 for exactly one cycle.
  - A direct change A->B without a release therefore produces a new pulse.
- Accept release: when stable_cnt reaches DEBOUNCE_FRAMES on NONE, key_held<=0. key_code retains its value and no pulse is produced.
- A held key produces no repeat pulses.
- Latency: from a stable press, key_valid asserts within (DEBOUNCE_FRAMES+1) frames + 3 cycles.
- Chatter shorter than DEBOUNCE_FRAMES frames produces no pulse and no release.

Decomposition:
- keypad_pkg:
  - KEY_MAP constant (16 entries indexed {row,col}).
  - KEY_NONE encoding: 5-bit {valid, code}.
  - Frame-result typedef.
- One sub-module: row_sync, a 4-bit 2-FF synchronizer with asynchronous reset to 4'b1111.
- Scan counters and debounce logic stay in keypad_scanner.

Test Plan:
Bench uses SCAN_CYCLES=8 and DEBOUNCE_FRAMES=3, so one frame = 32 cycles.
1. Deassert rst, no keys -> cols walks 1110,1101,1011,0111, changing every 8 cycles; key_valid never pulses; key_code=0; key_held=0.
2. Hold key "5" (row1, col1) steady -> exactly one key_valid pulse within 4 frames+3 cycles with key_code=4'h5 and key_held=1; no further pulses while held.
3. Release "5" for 3 frames -> key_held=0 and key_code stays 4'h5; press "D" (row3, col3) -> one pulse, key_code=4'hD.
4. Chatter "8" alternating press/release each frame for 10 frames -> zero key_valid pulses; key_held unchanged.
5. Hold "1" and "A" together -> multi_key=1; no pulse; key_held goes/stays 0 after 3 frames.
6. Assert rst mid-debounce of "3" (after 2 stable frames), then release rst while still holding -> outputs return to reset values immediately; pulse for "3" only after 3 fresh stable frames.
